// File: rtl/buffer_pixeles_mem.sv
// buffer_pixeles_mem: word-to-pixel FIFO. 32-bit words from memory are stored
// in a small circular buffer and presented one 8-bit pixel at a time,
// most-significant byte first, in show-ahead fashion.
module buffer_pixeles_mem #(
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_data,
  input  logic        save_mem_data,
  input  logic        read_pixel,
  output logic [7:0]  pixel,
  output logic        space_available,
  output logic        data_available
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic [1:0]        r_byte_idx;

  logic              w_space;
  logic              w_data;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_release;
  logic [31:0]       w_head;

  assign w_space   = (r_word_count != FULL_COUNT);
  assign w_data    = (r_word_count != '0);
  // Write acceptance uses pre-edge fullness, so a full buffer releasing a word
  // in the same cycle still rejects the incoming word.
  assign w_wr_en   = save_mem_data && w_space;
  assign w_rd_en   = read_pixel && w_data;
  assign w_release = w_rd_en && (r_byte_idx == 2'd3);
  assign w_head    = r_mem[r_rd_ptr];

  assign space_available = w_space;
  assign data_available  = w_data;

  // Select the current head byte; force zero while empty.
  always_comb begin
    pixel = '0;
    if (w_data) begin
      case (r_byte_idx)
        2'd0:    pixel = w_head[31:24];
        2'd1:    pixel = w_head[23:16];
        2'd2:    pixel = w_head[15:8];
        default: pixel = w_head[7:0];
      endcase
    end
  end

  // Word storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= memory_data;
    end
  end

  // Pointers, byte index and word occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_word_count <= '0;
      r_byte_idx   <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd_en) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (w_release) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr_en, w_release})
        2'b10:   r_word_count <= r_word_count + (ADDR_W + 1)'(1);
        2'b01:   r_word_count <= r_word_count - (ADDR_W + 1)'(1);
        default: r_word_count <= r_word_count;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_pixeles_mem.sv
// Directed testbench for buffer_pixeles_mem (DEPTH = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_buffer_pixeles_mem;

  logic        clk;
  logic        reset;
  logic [31:0] memory_data;
  logic        save_mem_data;
  logic        read_pixel;
  logic [7:0]  pixel;
  logic        space_available;
  logic        data_available;

  int unsigned n_cmp;
  int unsigned n_err;

  buffer_pixeles_mem #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .memory_data     (memory_data),
    .save_mem_data   (save_mem_data),
    .read_pixel      (read_pixel),
    .pixel           (pixel),
    .space_available (space_available),
    .data_available  (data_available)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one word for exactly one rising edge.
  task automatic write_word(input logic [31:0] w);
    @(negedge clk);
    memory_data   = w;
    save_mem_data = 1'b1;
    @(negedge clk);
    save_mem_data = 1'b0;
  endtask

  // Pop one pixel over exactly one rising edge.
  task automatic pulse_read();
    @(negedge clk);
    read_pixel = 1'b1;
    @(negedge clk);
    read_pixel = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if (pixel !== 8'h00) begin n_err++; $display("FAIL rst_pixel: got %h want 00", pixel); end
    n_cmp++;
    if (space_available !== 1'b1) begin n_err++; $display("FAIL rst_space: got %b want 1", space_available); end
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL rst_data: got %b want 0", data_available); end
    @(negedge clk);
    reset = 1'b0;
    // Load data then reset mid-cycle; outputs must clear before the next edge.
    write_word(32'h01020304);
    write_word(32'h05060708);
    pulse_read();
    n_cmp++;
    if (pixel !== 8'h02) begin n_err++; $display("FAIL prerst_pixel: got %h want 02", pixel); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pixel !== 8'h00) begin n_err++; $display("FAIL async_rst_pixel: got %h want 00", pixel); end
    n_cmp++;
    if (space_available !== 1'b1) begin n_err++; $display("FAIL async_rst_space: got %b want 1", space_available); end
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL async_rst_data: got %b want 0", data_available); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL post_rst_data: got %b want 0", data_available); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    write_word(32'hAABBCCDD);
    n_cmp++;
    if (data_available !== 1'b1) begin n_err++; $display("FAIL single_data: got %b want 1", data_available); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pixel !== exp_b[i]) begin n_err++; $display("FAIL single_px%0d: got %h want %h", i, pixel, exp_b[i]); end
      pulse_read();
    end
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL single_end_data: got %b want 0", data_available); end
    n_cmp++;
    if (pixel !== 8'h00) begin n_err++; $display("FAIL single_end_pixel: got %h want 00", pixel); end
  endtask

  task automatic test_full_stream();
    logic [7:0] exp_b [16];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAB, 8'hCD, 8'hEF, 8'h77,
              8'h12, 8'h34, 8'h56, 8'h78, 8'h87, 8'h65, 8'h43, 8'h21};
    write_word(32'hAABBCCDD);
    write_word(32'hABCDEF77);
    write_word(32'h12345678);
    n_cmp++;
    if (space_available !== 1'b1) begin n_err++; $display("FAIL full_space3: got %b want 1", space_available); end
    write_word(32'h87654321);
    n_cmp++;
    if (space_available !== 1'b0) begin n_err++; $display("FAIL full_space4: got %b want 0", space_available); end
    write_word(32'hDEADBEEF);
    n_cmp++;
    if (space_available !== 1'b0) begin n_err++; $display("FAIL full_overflow_space: got %b want 0", space_available); end
    @(negedge clk);
    read_pixel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (pixel !== exp_b[i]) begin n_err++; $display("FAIL full_px%0d: got %h want %h", i, pixel, exp_b[i]); end
      @(negedge clk);
    end
    read_pixel = 1'b0;
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL full_end_data: got %b want 0 (overflow word stored?)", data_available); end
    n_cmp++;
    if (pixel !== 8'h00) begin n_err++; $display("FAIL full_end_pixel: got %h want 00", pixel); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [16];
    exp_b = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
              8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    write_word(32'h01020304);
    write_word(32'h05060708);
    write_word(32'h090A0B0C);
    write_word(32'h0D0E0F10);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (space_available !== 1'b0) begin n_err++; $display("FAIL wrap_space_before%0d: got %b want 0", i, space_available); end
      pulse_read();
    end
    n_cmp++;
    if (space_available !== 1'b1) begin n_err++; $display("FAIL wrap_space_after: got %b want 1", space_available); end
    write_word(32'h11223344);
    @(negedge clk);
    read_pixel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (pixel !== exp_b[i]) begin n_err++; $display("FAIL wrap_px%0d: got %h want %h", i, pixel, exp_b[i]); end
      @(negedge clk);
    end
    read_pixel = 1'b0;
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL wrap_end_data: got %b want 0", data_available); end
  endtask

  // Full buffer releasing its head word while a write arrives: write rejected.
  task automatic test_full_release_collision();
    logic [7:0] exp_b [12];
    exp_b = '{8'hAB, 8'hCD, 8'hEF, 8'h77, 8'h12, 8'h34, 8'h56, 8'h78,
              8'h87, 8'h65, 8'h43, 8'h21};
    write_word(32'hAABBCCDD);
    write_word(32'hABCDEF77);
    write_word(32'h12345678);
    write_word(32'h87654321);
    pulse_read();
    pulse_read();
    pulse_read();
    n_cmp++;
    if (pixel !== 8'hDD) begin n_err++; $display("FAIL coll_head: got %h want DD", pixel); end
    @(negedge clk);
    read_pixel    = 1'b1;
    save_mem_data = 1'b1;
    memory_data   = 32'h99999999;
    @(negedge clk);
    read_pixel    = 1'b0;
    save_mem_data = 1'b0;
    n_cmp++;
    if (space_available !== 1'b1) begin n_err++; $display("FAIL coll_space: got %b want 1", space_available); end
    @(negedge clk);
    read_pixel = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (pixel !== exp_b[i]) begin n_err++; $display("FAIL coll_px%0d: got %h want %h", i, pixel, exp_b[i]); end
      @(negedge clk);
    end
    read_pixel = 1'b0;
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL coll_end_data: got %b want 0 (rejected word stored?)", data_available); end
  endtask

  task automatic test_empty_read();
    logic [7:0] exp_b [4];
    exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    @(negedge clk);
    read_pixel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (data_available !== 1'b0) begin n_err++; $display("FAIL empty_rd_data%0d: got %b want 0", i, data_available); end
    end
    read_pixel = 1'b0;
    write_word(32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pixel !== exp_b[i]) begin n_err++; $display("FAIL empty_px%0d: got %h want %h", i, pixel, exp_b[i]); end
      pulse_read();
    end
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL empty_end_data: got %b want 0", data_available); end
  endtask

  // Simultaneous write and read every cycle, checked against a byte-queue model.
  task automatic test_back_to_back();
    logic [7:0]  q [$];
    logic [31:0] w;
    int unsigned words;
    int unsigned guard;
    w = 32'h00010203;
    write_word(w);
    q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      w = {8'(8'h10 * i), 8'(8'h10 * i + 1), 8'(8'h10 * i + 2), 8'(8'h10 * i + 3)};
      words = (q.size() + 3) / 4;
      n_cmp++;
      if (pixel !== q[0]) begin n_err++; $display("FAIL b2b_px%0d: got %h want %h", i, pixel, q[0]); end
      n_cmp++;
      if (space_available !== (words != 4)) begin n_err++; $display("FAIL b2b_space%0d: got %b want %b", i, space_available, (words != 4)); end
      n_cmp++;
      if (data_available !== 1'b1) begin n_err++; $display("FAIL b2b_data%0d: got %b want 1", i, data_available); end
      memory_data   = w;
      save_mem_data = 1'b1;
      read_pixel    = 1'b1;
      if (words < 4) begin
        q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
      end
      void'(q.pop_front());
    end
    @(negedge clk);
    save_mem_data = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      n_cmp++;
      if (pixel !== q[0]) begin n_err++; $display("FAIL b2b_drain%0d: got %h want %h", guard, pixel, q[0]); end
      void'(q.pop_front());
      guard++;
      @(negedge clk);
    end
    read_pixel = 1'b0;
    n_cmp++;
    if (data_available !== 1'b0) begin n_err++; $display("FAIL b2b_end_data: got %b want 0", data_available); end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b0;
    memory_data   = '0;
    save_mem_data = 1'b0;
    read_pixel    = 1'b0;
    test_reset();
    test_single_word();
    test_full_stream();
    test_wrap();
    test_full_release_collision();
    test_empty_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
